// File: rtl/sub_mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package sub_mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
    function automatic int wd_width(input int tc);
        return (tc <= 0) ? 1 : $clog2(tc + 1);
    endfunction

endpackage

// File: rtl/sub_mem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the arbiter.
interface sub_mem_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int NumReq    = 2
);
    logic [NumReq-1:0]           req;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*DataWidth-1:0] req_wData;
    logic [NumReq-1:0]           req_write;
    logic [NumReq-1:0]           done;
    logic [DataWidth-1:0]        rData;
    logic [1:0]                  resp;
    logic                        mem_sel;
    logic [AddrWidth-1:0]        mem_addr;
    logic [DataWidth-1:0]        mem_wData;
    logic                        mem_write;
    logic                        mem_readyOut;
    logic [DataWidth-1:0]        mem_rData;
    logic [1:0]                  mem_resp;

    // Arbiter side.
    modport slave (
        input  req, req_addr, req_wData, req_write, mem_readyOut, mem_rData, mem_resp,
        output done, rData, resp, mem_sel, mem_addr, mem_wData, mem_write
    );

    // Requesters plus memory model side.
    modport master (
        output req, req_addr, req_wData, req_write, mem_readyOut, mem_rData, mem_resp,
        input  done, rData, resp, mem_sel, mem_addr, mem_wData, mem_write
    );
endinterface

// File: rtl/sub_mem_arbiter_rr_priority_picker.sv
// Cyclic first-set search starting at the round-robin pointer.
module rr_priority_picker #(
    parameter int NumReq = 2,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [PtrW-1:0]   idx_o
);

    // Walk offsets from far to near so the nearest set request wins.
    always_comb begin
        int          c;
        logic [PtrW-1:0] cw;
        c       = 0;
        cw      = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            c = int'(ptr_i) + i;
            if (c >= NumReq) c = c - NumReq;
            cw = PtrW'(c);
            if (req_i[cw]) begin
                valid_o = 1'b1;
                idx_o   = cw;
            end
        end
    end

endmodule

// File: rtl/sub_mem_arbiter.sv
// Round-robin arbiter sharing one memory port, with a stall watchdog.
module sub_mem_arbiter
    import sub_mem_arb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 255
) (
    input logic               clk,
    input logic               nReset,
    sub_mem_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NumReq);
    localparam int WW = wd_width(TimeoutCycles);
    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_BUSY = 1'(BUSY);
    // Watchdog value during the last allowed BUSY cycle.
    localparam logic [WW-1:0] WD_LAST = WW'(TimeoutCycles - 1);

    logic [0:0]           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [NumReq-1:0]    done_q, done_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           resp_q, resp_d;
    logic                 sel_q, sel_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [WW-1:0]        wd_q, wd_d;

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_nxt;
    logic          timeout;

    rr_priority_picker #(.NumReq(NumReq), .PtrW(PW)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    assign ptr_nxt = (idx_q == PW'(NumReq - 1)) ? '0 : idx_q + PW'(1);
    assign timeout = (TimeoutCycles != 0) && (wd_q >= WD_LAST);

    // Grant in IDLE, hold the latched request in BUSY, finish on ready or watchdog.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        done_d  = '0;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    addr_d  = bus.req_addr[pick_idx*AddrWidth +: AddrWidth];
                    wdata_d = bus.req_wData[pick_idx*DataWidth +: DataWidth];
                    write_d = bus.req_write[pick_idx];
                    sel_d   = 1'b1;
                    wd_d    = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_readyOut) begin
                    done_d[idx_q] = 1'b1;
                    rdata_d = bus.mem_rData;
                    resp_d  = bus.mem_resp;
                    sel_d   = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    done_d[idx_q] = 1'b1;
                    rdata_d = '0;
                    resp_d  = RESP_ERROR;
                    sel_d   = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = S_IDLE;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.rData     = rdata_q;
    assign bus.resp      = resp_q;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wData = wdata_q;
    assign bus.mem_write = write_q;

endmodule
